arch_map_rt: RTL and testbench
==============================

ARCH_MAP_RT -- requirements
Module: arch_map_rt

Interface
REQ-001 SHALL have parameter R_WIDTH, default 3: commit lanes per cycle.
REQ-002 SHALL have parameter REG_SIZE, default 32: architectural registers.
REQ-003 SHALL have parameter PHY_SIZE, default 64: physical registers; PIDX = clog2(PHY_SIZE), AIDX = clog2(REG_SIZE).
REQ-004 SHALL have parameter RCV_WIDTH, default 4: map entries streamed per recovery cycle; REG_SIZE % RCV_WIDTH == 0.
REQ-005 Ports: clock  in  1  rising-edge clock; reset is synchronous, active-high.
REQ-006 Ports: reset  in  1  synchronous, active-high reset.
REQ-007 Ports: commit_valid  in  R_WIDTH  per-lane retire strobe; lane 0 oldest.
REQ-008 Ports: commit_arch  in  R_WIDTH x AIDX  retiring destination arch register.
REQ-009 Ports: commit_phy  in  R_WIDTH x PIDX  retiring destination physical tag.
REQ-010 Ports: commit_ready  out  1  high when commits are accepted (= !busy).
REQ-011 Ports: free_valid  out  R_WIDTH  per-lane freed-tag strobe.
REQ-012 Ports: free_phy  out  R_WIDTH x PIDX  superseded physical tag to return to free list.
REQ-013 Ports: recover_req  in  1  single-cycle request to stream the committed map.
REQ-014 Ports: busy  out  1  high while recovery stream in progress.
REQ-015 Ports: rcv_valid  out  1  stream beat valid.
REQ-016 Ports: rcv_base  out  AIDX  arch index of rcv_phy[0] in current beat.
REQ-017 Ports: rcv_phy  out  RCV_WIDTH x PIDX  map[rcv_base+k] for lane k.
REQ-018 Ports: rcv_done  out  1  high with the final beat only.

Function
REQ-019 Lane i SHALL update the map only if commit_valid[i] && commit_ready && commit_arch[i] != 0; arch reg 0 is never remapped.
REQ-020 Within one cycle, multiple lanes to the same arch reg SHALL resolve highest lane wins.
REQ-021 For each updating lane, freed tag SHALL be prior mapping: commit_phy of nearest older lane in the group to same arch reg, else map value at start of cycle.
REQ-022 free_valid/free_phy SHALL be registered: appear exactly 1 cycle after commit, held 1 cycle; non-updating lanes give free_valid=0.
REQ-023 Commits with commit_ready low SHALL be ignored (no map change, no free output).
REQ-024 FSM states IDLE and STREAM; IDLE -> STREAM on recover_req; STREAM -> IDLE after beat REG_SIZE/RCV_WIDTH-1.
REQ-025 recover_req in IDLE SHALL apply same-cycle commits first; streamed snapshot includes them.
REQ-026 recover_req while busy SHALL be ignored.
REQ-027 STREAM: beats SHALL start the cycle after entry, rcv_base = 0, RCV_WIDTH, 2*RCV_WIDTH, ... one beat per cycle, no gaps, no backpressure.
REQ-028 busy SHALL be high from the cycle after recover_req through the final beat inclusive; commit_ready = !busy.
REQ-029 rcv_valid, rcv_done SHALL be 0 in IDLE; rcv_base/rcv_phy don't-care when rcv_valid=0.
REQ-030 rcv_base counter SHALL wrap to 0 when returning to IDLE.

Reset
REQ-031 On reset map[i] SHALL be i for all i < REG_SIZE (PHY_SIZE >= REG_SIZE).
REQ-032 On reset: FSM IDLE, busy 0, commit_ready 1, rcv_valid 0, rcv_done 0, rcv_base 0, free_valid 0.
REQ-033 Reset mid-stream SHALL abort immediately; next cycle all outputs at reset values.
REQ-034 Reset SHALL dominate same-cycle commits and recover_req.

Configuration
REQ-035 Macro ARCH_MAP_FREE_OUT_EN defined: free_valid/free_phy behave per REQ-021/022.
REQ-036 Macro ARCH_MAP_FREE_OUT_EN undefined: free_valid tied 0, free_phy tied 0, no freed-tag logic or registers; map behaviour unchanged.

Verification
REQ-037 Reset, recover_req -> 8 beats (defaults), beat b rcv_phy = {4b..4b+3}, rcv_done on beat 7 only.
REQ-038 Commit lane0 arch 5 -> phy 40 -> next cycle free_valid[0]=1, free_phy[0]=5; later stream shows map[5]=40.
REQ-039 Same cycle lanes 0,1,2 all arch 7 -> phy 33,34,35 -> frees 7,33,34; map[7]=35.
REQ-040 Commit arch 0 -> phy 50 -> no free, map[0] stays 0.
REQ-041 Commit arch 3 -> 45 with recover_req same cycle -> beat 0 lane 3 = 45; commits during busy ignored; second recover_req during busy ignored.
REQ-042 Reset asserted on beat 3 -> next cycle rcv_valid=0, busy=0, map identity.

Source files
------------

// File: rtl/arch_map_rt.sv
// Committed (architectural) rename map: retires up to R_WIDTH lanes per cycle and streams a map snapshot on recover_req.
// Latency: map updates at the commit edge, freed tags one cycle later, stream beats start the cycle after recover_req.
// Backpressure: none on the stream; commit_ready drops while streaming. Freed-tag outputs exist only with ARCH_MAP_FREE_OUT_EN.
module arch_map_rt #(
    parameter int R_WIDTH   = 3,
    parameter int REG_SIZE  = 32,
    parameter int PHY_SIZE  = 64,
    parameter int RCV_WIDTH = 4,
    localparam int PIDX = $clog2(PHY_SIZE),
    localparam int AIDX = $clog2(REG_SIZE)
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [R_WIDTH-1:0]                   commit_valid,
    input  logic [R_WIDTH-1:0][AIDX-1:0]         commit_arch,
    input  logic [R_WIDTH-1:0][PIDX-1:0]         commit_phy,
    output logic                                 commit_ready,
    output logic [R_WIDTH-1:0]                   free_valid,
    output logic [R_WIDTH-1:0][PIDX-1:0]         free_phy,
    input  logic                                 recover_req,
    output logic                                 busy,
    output logic                                 rcv_valid,
    output logic [AIDX-1:0]                      rcv_base,
    output logic [RCV_WIDTH-1:0][PIDX-1:0]       rcv_phy,
    output logic                                 rcv_done
);

    localparam int NBEATS = REG_SIZE / RCV_WIDTH;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic [PIDX-1:0]    map_q [REG_SIZE];
    logic [PIDX-1:0]    map_d [REG_SIZE];
    logic [0:0]         state_q, state_d;
    logic [BW-1:0]      beat_q, beat_d;
    logic [R_WIDTH-1:0] upd;
    logic               last_beat;

    assign busy         = (state_q == ST_STREAM);
    assign commit_ready = !busy;
    assign last_beat    = (beat_q == BW'(NBEATS - 1));

    // Arch register 0 is hard-wired and never remapped.
    always_comb begin
        for (int i = 0; i < R_WIDTH; i++) begin
            upd[i] = commit_valid[i] && commit_ready && (commit_arch[i] != '0);
        end
    end

    // Ascending lane order makes the youngest lane win on a shared arch register.
    always_comb begin
        map_d = map_q;
        for (int i = 0; i < R_WIDTH; i++) begin
            if (upd[i]) begin
                map_d[commit_arch[i]] = commit_phy[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (recover_req) begin
                    state_d = ST_STREAM;
                    beat_d  = '0;
                end
            end
            ST_STREAM: begin
                if (last_beat) begin
                    state_d = ST_IDLE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int a = 0; a < REG_SIZE; a++) begin
                map_q[a] <= PIDX'(a);
            end
            state_q <= ST_IDLE;
            beat_q  <= '0;
        end else begin
            map_q   <= map_d;
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Map cannot change while streaming, so map_q is a stable snapshot.
    always_comb begin
        int base_i;
        base_i    = int'(beat_q) * RCV_WIDTH;
        rcv_valid = busy;
        rcv_done  = busy && last_beat;
        rcv_base  = AIDX'(base_i);
        for (int k = 0; k < RCV_WIDTH; k++) begin
            rcv_phy[k] = map_q[AIDX'(base_i + k)];
        end
    end

`ifdef ARCH_MAP_FREE_OUT_EN
    logic [R_WIDTH-1:0]           free_vld_q, free_vld_d;
    logic [R_WIDTH-1:0][PIDX-1:0] free_phy_q, free_phy_d;

    // Prior mapping is the nearest older same-cycle writer, else the start-of-cycle map.
    always_comb begin
        free_vld_d = upd;
        for (int i = 0; i < R_WIDTH; i++) begin
            free_phy_d[i] = map_q[commit_arch[i]];
            for (int j = 0; j < R_WIDTH; j++) begin
                if (j < i && upd[j] && commit_arch[j] == commit_arch[i]) begin
                    free_phy_d[i] = commit_phy[j];
                end
            end
            if (!upd[i]) begin
                free_phy_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            free_vld_q <= '0;
            free_phy_q <= '0;
        end else begin
            free_vld_q <= free_vld_d;
            free_phy_q <= free_phy_d;
        end
    end

    assign free_valid = free_vld_q;
    assign free_phy   = free_phy_q;
`else
    assign free_valid = '0;
    assign free_phy   = '0;
`endif

endmodule

// File: tb/tb_arch_map_rt.sv
module tb_arch_map_rt;

    localparam int NL = 3;
    localparam int NR = 32;
    localparam int NK = 4;
    localparam int NB = NR / NK;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [NL-1:0]         commit_valid;
    logic [NL-1:0][4:0]    commit_arch;
    logic [NL-1:0][5:0]    commit_phy;
    logic                  commit_ready;
    logic [NL-1:0]         free_valid;
    logic [NL-1:0][5:0]    free_phy;
    logic                  recover_req;
    logic                  busy;
    logic                  rcv_valid;
    logic [4:0]            rcv_base;
    logic [NK-1:0][5:0]    rcv_phy;
    logic                  rcv_done;

    arch_map_rt dut (
        .clock(clock), .reset(reset),
        .commit_valid(commit_valid), .commit_arch(commit_arch), .commit_phy(commit_phy),
        .commit_ready(commit_ready), .free_valid(free_valid), .free_phy(free_phy),
        .recover_req(recover_req), .busy(busy), .rcv_valid(rcv_valid),
        .rcv_base(rcv_base), .rcv_phy(rcv_phy), .rcv_done(rcv_done)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: architectural map, stream position, expected frees.
    int m_map  [NR];
    int m_snap [NR];
    int seen   [NR];
    bit m_busy;
    int m_beat;
    bit m_fv [NL];
    int m_fp [NL];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        commit_valid = '0;
        commit_arch  = '0;
        commit_phy   = '0;
        recover_req  = 1'b0;
    endtask

    task automatic set_commit(input int lane, input int arch, input int phy);
        commit_valid[lane] = 1'b1;
        commit_arch[lane]  = 5'(arch);
        commit_phy[lane]   = 6'(phy);
    endtask

    task automatic tick();
        int a;
        chk("commit_ready_pre", commit_ready, 32'(!m_busy));
        for (int i = 0; i < NL; i++) m_fv[i] = 1'b0;
        if (reset) begin
            for (int r = 0; r < NR; r++) m_map[r] = r;
            m_busy = 1'b0;
            m_beat = 0;
        end else if (!m_busy) begin
            for (int i = 0; i < NL; i++) begin
                a = int'(commit_arch[i]);
                if (commit_valid[i] && a != 0) begin
                    m_fv[i] = 1'b1;
                    m_fp[i] = m_map[a];
                    m_map[a] = int'(commit_phy[i]);
                end
            end
            if (recover_req) begin
                m_snap = m_map;
                m_busy = 1'b1;
                m_beat = 0;
            end
        end else if (m_beat == NB - 1) begin
            m_busy = 1'b0;
            m_beat = 0;
        end else begin
            m_beat++;
        end

        @(posedge clock);
        #1;

        chk("busy", busy, 32'(m_busy));
        chk("commit_ready", commit_ready, 32'(!m_busy));
        chk("rcv_valid", rcv_valid, 32'(m_busy));
        chk("rcv_done", rcv_done, 32'(m_busy && m_beat == NB - 1));
        if (m_busy) begin
            chk("rcv_base", rcv_base, 32'(m_beat * NK));
            for (int k = 0; k < NK; k++) begin
                chk("rcv_phy", rcv_phy[k], 32'(m_snap[m_beat * NK + k]));
                seen[m_beat * NK + k] = int'(rcv_phy[k]);
            end
        end
`ifdef ARCH_MAP_FREE_OUT_EN
        for (int i = 0; i < NL; i++) begin
            chk("free_valid", free_valid[i], 32'(m_fv[i]));
            if (m_fv[i]) chk("free_phy", free_phy[i], 32'(m_fp[i]));
        end
`else
        chk("free_valid_tied", free_valid, 0);
        chk("free_phy_tied", free_phy, 0);
`endif
    endtask

    task automatic stream_all();
        clear_inputs();
        recover_req = 1'b1;
        tick();
        recover_req = 1'b0;
        repeat (NB) tick();
    endtask

    initial begin
        for (int r = 0; r < NR; r++) begin
            m_map[r]  = r;
            m_snap[r] = r;
            seen[r]   = -1;
        end
        m_busy = 1'b0;
        m_beat = 0;
        clear_inputs();

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_rcv_base", rcv_base, 0);
        chk("rst_free_valid", free_valid, 0);

        // Identity map streamed after reset
        stream_all();
        for (int r = 0; r < NR; r++) chk("identity_map", seen[r], r);

        // Single commit arch 5 -> 40
        clear_inputs();
        set_commit(0, 5, 40);
        tick();
`ifdef ARCH_MAP_FREE_OUT_EN
        chk("req38_free_valid0", free_valid[0], 1);
        chk("req38_free_phy0", free_phy[0], 5);
`endif

        // Three lanes hitting arch 7
        clear_inputs();
        set_commit(0, 7, 33);
        set_commit(1, 7, 34);
        set_commit(2, 7, 35);
        tick();
`ifdef ARCH_MAP_FREE_OUT_EN
        chk("req39_free_valid", free_valid, 7);
        chk("req39_free0", free_phy[0], 7);
        chk("req39_free1", free_phy[1], 33);
        chk("req39_free2", free_phy[2], 34);
`endif

        // Arch 0 is never remapped
        clear_inputs();
        set_commit(0, 0, 50);
        tick();
        chk("req40_no_free", free_valid, 0);
        stream_all();
        chk("req38_map5", seen[5], 40);
        chk("req39_map7", seen[7], 35);
        chk("req40_map0", seen[0], 0);

        // Commit with same-cycle recover, then ignored traffic while busy
        clear_inputs();
        set_commit(0, 3, 45);
        recover_req = 1'b1;
        tick();
        chk("req41_beat0_lane3", rcv_phy[3], 45);
        clear_inputs();
        set_commit(1, 9, 60);
        recover_req = 1'b1;
        repeat (NB - 1) tick();
        clear_inputs();
        tick();
        chk("req41_idle_after", busy, 0);
        stream_all();
        chk("req41_map3", seen[3], 45);
        chk("req41_map9_kept", seen[9], 9);

        // Reset on beat 3
        clear_inputs();
        recover_req = 1'b1;
        tick();
        recover_req = 1'b0;
        repeat (3) tick();
        chk("req42_on_beat3", rcv_base, 12);
        reset = 1'b1;
        set_commit(0, 4, 44);
        recover_req = 1'b1;
        tick();
        reset = 1'b0;
        chk("req42_rcv_valid", rcv_valid, 0);
        chk("req42_busy", busy, 0);
        stream_all();
        for (int r = 0; r < NR; r++) chk("req42_identity", seen[r], r);

        // Randomized traffic with occasional recover and reset
        for (int c = 0; c < 800; c++) begin
            clear_inputs();
            for (int i = 0; i < NL; i++) begin
                if ($urandom_range(0, 3) != 0) begin
                    if ($urandom_range(0, 1) == 0)
                        set_commit(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 63)));
                    else
                        set_commit(i, int'($urandom_range(0, NR - 1)), int'($urandom_range(0, 63)));
                end
            end
            recover_req = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0;
        clear_inputs();
        repeat (NB + 1) tick();
        stream_all();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
